// File: rtl/arp_responder.sv
// arp_responder: checks a received ARP packet for a request aimed at our IP and builds the 42-byte reply.
// Latency: first tx write 10 cycles after arp_ready is sampled; xmit and done follow the last write back to back.
// Backpressure: none; arp_ready low during CHECK/COPY aborts, and WAITREL holds until arp_ready drops.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   arp_ready           buffer grant from the packet handler
//   mac, ip             our addresses (sampled once per grant)
//   rxd                 receive-buffer data, one cycle behind arp_rxa
//   arp_rxa             receive-buffer read address
//   arp_txa/txd/we      transmit-buffer write port
//   arp_len             reply length (42 while a reply is in the buffer)
//   arp_xmit, arp_done  one-cycle transmit request and completion strobes
`timescale 1ns/1ps
module arp_responder (
  input  logic        clk,
  input  logic        reset,
  input  logic        arp_ready,
  input  logic [47:0] mac,
  input  logic [31:0] ip,
  input  logic [7:0]  rxd,
  output logic [5:0]  arp_rxa,
  output logic [5:0]  arp_txa,
  output logic [7:0]  arp_txd,
  output logic        arp_we,
  output logic [5:0]  arp_len,
  output logic        arp_xmit,
  output logic        arp_done
);

  typedef enum logic [2:0] {IDLE, CHECK, COPY, XMIT, DONE, WAITREL} state_t;

  localparam logic [5:0] REPLY_LEN = 6'd42;
  localparam logic [5:0] LAST_BYTE = 6'd41;
  localparam logic [5:0] SHA_ADDR  = 6'd22;

  state_t      state;
  logic [47:0] mac_h;
  logic [31:0] ip_h;
  logic [2:0]  chk_idx;    // index of the check address currently on arp_rxa
  logic        chk_vld;    // rxd holds the byte for check index chk_idx-1
  logic        chk_drain;  // all 8 addresses issued, last compare pending
  logic        fail;
  logic [5:0]  byte_idx;   // reply byte whose rx data is on rxd this cycle

  logic [7:0]  mac_b [0:5];
  logic [7:0]  ip_b  [0:3];
  logic [2:0]  chk_cmp;
  logic [7:0]  chk_exp;
  logic        chk_mis;
  logic [7:0]  tx_nxt;

  for (genvar g = 0; g < 6; g++) begin : g_mac
    assign mac_b[g] = mac_h[47-8*g -: 8];
  end
  for (genvar g = 0; g < 4; g++) begin : g_ip
    assign ip_b[g] = ip_h[31-8*g -: 8];
  end

  // Receive addresses inspected during CHECK: ptype, opcode, target IP.
  function automatic logic [5:0] chk_addr(input logic [2:0] idx);
    case (idx)
      3'd0:    chk_addr = 6'd16;
      3'd1:    chk_addr = 6'd17;
      3'd2:    chk_addr = 6'd20;
      3'd3:    chk_addr = 6'd21;
      3'd4:    chk_addr = 6'd38;
      3'd5:    chk_addr = 6'd39;
      3'd6:    chk_addr = 6'd40;
      default: chk_addr = 6'd41;
    endcase
  endfunction

  // Receive address feeding reply byte idx; constant bytes park the address at 0.
  function automatic logic [5:0] rx_src(input logic [5:0] idx);
    if (idx <= 6'd5)
      rx_src = idx + 6'd22;
    else if (idx >= 6'd32 && idx <= LAST_BYTE)
      rx_src = idx - 6'd10;
    else
      rx_src = 6'd0;
  endfunction

  // The compare slot trails the address slot by one; chk_idx wraps 7->0 on
  // entering the drain cycle so chk_idx-1 still points at entry 7.
  always_comb begin
    chk_cmp = chk_idx - 3'd1;
    case (chk_cmp)
      3'd0:    chk_exp = 8'h08;
      3'd1:    chk_exp = 8'h00;
      3'd2:    chk_exp = 8'h00;
      3'd3:    chk_exp = 8'h01;
      default: chk_exp = ip_b[chk_cmp[1:0]];
    endcase
  end

  assign chk_mis = chk_vld && (rxd != chk_exp);

  always_comb begin
    tx_nxt = 8'h00;
    if (byte_idx <= 6'd5 || byte_idx >= 6'd32)
      tx_nxt = rxd;
    else if (byte_idx <= 6'd11)
      tx_nxt = mac_b[3'(byte_idx - 6'd6)];
    else if (byte_idx >= 6'd22 && byte_idx <= 6'd27)
      tx_nxt = mac_b[3'(byte_idx - 6'd22)];
    else if (byte_idx >= 6'd28)
      tx_nxt = ip_b[2'(byte_idx - 6'd28)];
    else begin
      case (byte_idx)
        6'd12:   tx_nxt = 8'h08;
        6'd13:   tx_nxt = 8'h06;
        6'd15:   tx_nxt = 8'h01;
        6'd16:   tx_nxt = 8'h08;
        6'd18:   tx_nxt = 8'h06;
        6'd19:   tx_nxt = 8'h04;
        6'd21:   tx_nxt = 8'h02;
        default: tx_nxt = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mac_h     <= '0;
      ip_h      <= '0;
      chk_idx   <= '0;
      chk_vld   <= 1'b0;
      chk_drain <= 1'b0;
      fail      <= 1'b0;
      byte_idx  <= '0;
      arp_rxa   <= '0;
      arp_txa   <= '0;
      arp_txd   <= '0;
      arp_we    <= 1'b0;
      arp_len   <= '0;
      arp_xmit  <= 1'b0;
      arp_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arp_ready) begin
            mac_h     <= mac;
            ip_h      <= ip;
            fail      <= 1'b0;
            chk_idx   <= 3'd0;
            chk_vld   <= 1'b0;
            chk_drain <= 1'b0;
            arp_rxa   <= chk_addr(3'd0);
            state     <= CHECK;
          end
        end

        CHECK: begin
          if (!arp_ready) begin
            arp_rxa <= '0;
            state   <= IDLE;
          end else if (chk_drain) begin
            byte_idx <= '0;
            if (fail || chk_mis) begin
              arp_rxa <= '0;
              state   <= DONE;
            end else begin
              // Byte 0's address was already issued in the drain slot.
              arp_rxa <= rx_src(6'd1);
              state   <= COPY;
            end
          end else begin
            if (chk_mis)
              fail <= 1'b1;
            chk_vld   <= 1'b1;
            chk_idx   <= chk_idx + 3'd1;
            chk_drain <= (chk_idx == 3'd7);
            arp_rxa   <= (chk_idx == 3'd7) ? SHA_ADDR : chk_addr(chk_idx + 3'd1);
          end
        end

        COPY: begin
          if (!arp_ready) begin
            arp_rxa <= '0;
            arp_txa <= '0;
            arp_txd <= '0;
            arp_we  <= 1'b0;
            arp_len <= '0;
            state   <= IDLE;
          end else begin
            arp_we  <= 1'b1;
            arp_txa <= byte_idx;
            arp_txd <= tx_nxt;
            arp_len <= REPLY_LEN;
            arp_rxa <= rx_src(byte_idx + 6'd2);
            if (byte_idx == LAST_BYTE)
              state <= XMIT;
            else
              byte_idx <= byte_idx + 6'd1;
          end
        end

        XMIT: begin
          arp_we   <= 1'b0;
          arp_txa  <= '0;
          arp_txd  <= '0;
          arp_rxa  <= '0;
          arp_xmit <= 1'b1;
          state    <= DONE;
        end

        DONE: begin
          arp_xmit <= 1'b0;
          arp_done <= 1'b1;
          state    <= WAITREL;
        end

        WAITREL: begin
          arp_done <= 1'b0;
          if (!arp_ready) begin
            arp_len <= '0;
            state   <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arp_responder.sv
// tb_arp_responder: directed stimulus for arp_responder with a receive-buffer model and reply scoreboard.
// Latency: expected reply bytes are queued at request time and popped on each arp_we.
// Backpressure: exercises grant hold, grant drop mid-copy and reset mid-copy.
`timescale 1ns/1ps
module tb_arp_responder;

  logic        clk;
  logic        reset;
  logic        arp_ready;
  logic [47:0] mac;
  logic [31:0] ip;
  logic [7:0]  rxd;
  logic [5:0]  arp_rxa;
  logic [5:0]  arp_txa;
  logic [7:0]  arp_txd;
  logic        arp_we;
  logic [5:0]  arp_len;
  logic        arp_xmit;
  logic        arp_done;

  arp_responder dut (
    .clk(clk), .reset(reset), .arp_ready(arp_ready), .mac(mac), .ip(ip), .rxd(rxd),
    .arp_rxa(arp_rxa), .arp_txa(arp_txa), .arp_txd(arp_txd), .arp_we(arp_we),
    .arp_len(arp_len), .arp_xmit(arp_xmit), .arp_done(arp_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int we_cnt = 0, xmit_cnt = 0, done_cnt = 0;
  int first_we_cyc = 0, last_we_cyc = 0, xmit_cyc = 0, done_cyc = 0;
  logic we_d = 1'b0;

  logic [7:0]  rxbuf [0:63];
  logic [13:0] exp_q [$];

  int we0, x0, d0, t0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Synchronous-read receive buffer.
  always @(posedge clk) rxd <= rxbuf[arp_rxa];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [13:0] e;
    if (arp_we) begin
      if (!we_d) first_we_cyc = cyc;
      last_we_cyc = cyc;
      we_cnt++;
      chk("sb_has_entry", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("tx_addr_data", {arp_txa, arp_txd}, e);
      end
    end
    we_d = arp_we;
    if (arp_xmit) begin
      xmit_cnt++;
      xmit_cyc = cyc;
      chk("xmit_done_excl", arp_done, 0);
      chk("len_at_xmit", arp_len, 42);
    end
    if (arp_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, {arp_rxa, arp_txa, arp_txd, arp_we, arp_len, arp_xmit, arp_done}, 0);
  endtask

  task automatic set_pkt(input logic [47:0] sha, input logic [31:0] spa, input logic [31:0] tpa,
                         input logic [15:0] op, input logic [15:0] ptype);
    for (int i = 0; i < 64; i++) rxbuf[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      rxbuf[i]    = 8'hff;
      rxbuf[6+i]  = 8'(sha >> (40 - 8*i));
      rxbuf[22+i] = 8'(sha >> (40 - 8*i));
    end
    rxbuf[12] = 8'h08; rxbuf[13] = 8'h06;
    rxbuf[14] = 8'h00; rxbuf[15] = 8'h01;
    rxbuf[16] = ptype[15:8]; rxbuf[17] = ptype[7:0];
    rxbuf[18] = 8'h06; rxbuf[19] = 8'h04;
    rxbuf[20] = op[15:8]; rxbuf[21] = op[7:0];
    for (int i = 0; i < 4; i++) begin
      rxbuf[28+i] = 8'(spa >> (24 - 8*i));
      rxbuf[38+i] = 8'(tpa >> (24 - 8*i));
    end
  endtask

  // Reply frame: dst=requester, src=us, ethertype ARP, Ethernet/IPv4 reply, sender=us, target=requester.
  task automatic push_reply(input logic [47:0] sha, input logic [31:0] spa,
                            input logic [47:0] my_mac, input logic [31:0] my_ip);
    logic [7:0] r [0:41];
    logic [7:0] hdr [0:9];
    hdr = '{8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h02};
    for (int i = 0; i < 6; i++) begin
      r[i]    = 8'(sha >> (40 - 8*i));
      r[6+i]  = 8'(my_mac >> (40 - 8*i));
      r[22+i] = 8'(my_mac >> (40 - 8*i));
      r[32+i] = 8'(sha >> (40 - 8*i));
    end
    for (int i = 0; i < 10; i++) r[12+i] = hdr[i];
    for (int i = 0; i < 4; i++) begin
      r[28+i] = 8'(my_ip >> (24 - 8*i));
      r[38+i] = 8'(spa >> (24 - 8*i));
    end
    for (int i = 0; i < 42; i++) exp_q.push_back({6'(i), r[i]});
  endtask

  task automatic start_txn();
    we0 = we_cnt; x0 = xmit_cnt; d0 = done_cnt;
    arp_ready = 1'b1;
    t0 = cyc;
  endtask

  task automatic wait_done(input int bound);
    for (int i = 0; i < bound && done_cnt == d0; i++) step();
    chk("done_seen", done_cnt - d0, 1);
  endtask

  task automatic check_txn(input bit good);
    chk("we_count", we_cnt - we0, good ? 42 : 0);
    chk("xmit_count", xmit_cnt - x0, good ? 1 : 0);
    chk("done_count", done_cnt - d0, 1);
    chk("sb_drained", exp_q.size(), 0);
    if (good) begin
      chk("first_we_latency_ok", (first_we_cyc - t0 - 1) <= 12, 1);
      chk("xmit_after_last_we", xmit_cyc - last_we_cyc, 1);
      chk("done_after_xmit", done_cyc - xmit_cyc, 1);
    end else begin
      chk("reject_latency_ok", (done_cyc - t0 - 1) <= 11, 1);
    end
  endtask

  task automatic release_grant();
    arp_ready = 1'b0;
    step();
    step();
    chk_idle("idle_after_release");
  endtask

  localparam logic [47:0] MY_MAC  = 48'h02_00_00_00_00_01;
  localparam logic [31:0] MY_IP   = 32'hc0_a8_00_02;
  localparam logic [47:0] REQ_MAC = 48'haa_bb_cc_dd_ee_ff;
  localparam logic [31:0] REQ_IP  = 32'hc0_a8_00_01;

  initial begin
    reset = 1'b1;
    arp_ready = 1'b0;
    mac = MY_MAC;
    ip = MY_IP;
    for (int i = 0; i < 64; i++) rxbuf[i] = 8'h00;
    repeat (3) step();
    chk_idle("reset_outputs");
    reset = 1'b0;
    step();

    // Valid request; mac/ip change mid-transaction must be ignored; grant held after done.
    set_pkt(REQ_MAC, REQ_IP, MY_IP, 16'h0001, 16'h0800);
    push_reply(REQ_MAC, REQ_IP, MY_MAC, MY_IP);
    start_txn();
    repeat (3) step();
    mac = 48'h0a_0b_0c_0d_0e_0f;
    ip = 32'h0a_00_00_01;
    wait_done(80);
    check_txn(1'b1);
    repeat (5) step();
    chk("waitrel_no_redo", done_cnt - d0, 1);
    chk("waitrel_no_write", we_cnt - we0, 42);
    chk("len_in_waitrel", arp_len, 42);
    release_grant();
    mac = MY_MAC;
    ip = MY_IP;

    // Request for another IP.
    set_pkt(REQ_MAC, REQ_IP, 32'hc0_a8_00_03, 16'h0001, 16'h0800);
    start_txn();
    wait_done(20);
    check_txn(1'b0);
    release_grant();

    // Received ARP reply.
    set_pkt(REQ_MAC, REQ_IP, MY_IP, 16'h0002, 16'h0800);
    start_txn();
    wait_done(20);
    check_txn(1'b0);
    release_grant();

    // IPv6 protocol type.
    set_pkt(REQ_MAC, REQ_IP, MY_IP, 16'h0001, 16'h86dd);
    start_txn();
    wait_done(20);
    check_txn(1'b0);
    release_grant();

    // Grant dropped at the 20th copy write.
    set_pkt(REQ_MAC, REQ_IP, MY_IP, 16'h0001, 16'h0800);
    push_reply(REQ_MAC, REQ_IP, MY_MAC, MY_IP);
    start_txn();
    for (int i = 0; i < 60 && (we_cnt - we0) < 20; i++) step();
    chk("abort_reached_20", we_cnt - we0, 20);
    arp_ready = 1'b0;
    step();
    chk("abort_we_low", arp_we, 0);
    repeat (3) step();
    chk("abort_we_count", we_cnt - we0, 20);
    chk("abort_no_xmit", xmit_cnt - x0, 0);
    chk("abort_no_done", done_cnt - d0, 0);
    chk_idle("abort_idle");
    exp_q.delete();

    // Normal request right after the abort.
    push_reply(REQ_MAC, REQ_IP, MY_MAC, MY_IP);
    start_txn();
    wait_done(80);
    check_txn(1'b1);
    release_grant();

    // Reset mid-copy.
    push_reply(REQ_MAC, REQ_IP, MY_MAC, MY_IP);
    start_txn();
    for (int i = 0; i < 60 && (we_cnt - we0) < 10; i++) step();
    chk("reset_reached_10", we_cnt - we0, 10);
    reset = 1'b1;
    arp_ready = 1'b0;
    step();
    chk_idle("reset_mid_copy");
    reset = 1'b0;
    exp_q.delete();
    step();

    // Full reply after reset, different requester.
    set_pkt(48'h11_22_33_44_55_66, 32'h0a_00_00_07, MY_IP, 16'h0001, 16'h0800);
    push_reply(48'h11_22_33_44_55_66, 32'h0a_00_00_07, MY_MAC, MY_IP);
    start_txn();
    wait_done(80);
    check_txn(1'b1);
    release_grant();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
